// File: rtl/interleaver_commutator_ctrl.sv
// Commutator control for a convolutional byte interleaver: tracks packet
// alignment from sync bytes and steers each byte to its branch buffer.
module interleaver_commutator_ctrl #(
  parameter int BRANCHES = 12,
  parameter int DEPTH    = 17,
  parameter int PKT_LEN  = 204
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                sync_in,
  output logic [BRANCHES-1:0] buf_en,
  output logic [3:0]          branch_sel,
  output logic                locked,
  output logic                pkt_err,
  output logic                fill_done
);

  localparam int             BCW       = $clog2(PKT_LEN);
  localparam logic [11:0]    FILL      = 12'(DEPTH * BRANCHES * (BRANCHES - 1));
  localparam logic [3:0]     LAST_BR   = 4'(BRANCHES - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(PKT_LEN - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [3:0]     nxt_br_q, nxt_br_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [1:0]     miss_cnt_q, miss_cnt_d;
  logic [11:0]    fill_cnt_q, fill_cnt_d;
  logic           locked_q, locked_d;
  logic           pkt_err_q, pkt_err_d;
  logic           fill_done_q, fill_done_d;

  logic           hunt_sync_s;
  logic           misplaced_s;
  logic           missing_s;
  logic [3:0]     cur_br_s;

  function automatic logic [BRANCHES-1:0] br_onehot(input logic [3:0] idx);
    logic [BRANCHES-1:0] v;
    for (int i = 0; i < BRANCHES; i++) begin
      v[i] = (idx == 4'(i));
    end
    return v;
  endfunction

  // Branch selection for the byte presented this cycle.
  always_comb begin
    hunt_sync_s = (state_q == HUNT) && en && sync_in;
    misplaced_s = (state_q == LOCKED) && en && sync_in && (byte_cnt_q != '0);
    missing_s   = (state_q == LOCKED) && en && !sync_in && (byte_cnt_q == '0);
    if (hunt_sync_s || misplaced_s) begin
      cur_br_s = 4'd0;
    end else begin
      cur_br_s = nxt_br_q;
    end
  end

  // Buffer strobes; HUNT only passes the sync byte and reset blanks everything.
  always_comb begin
    buf_en     = '0;
    branch_sel = 4'd0;
    if (!reset) begin
      buf_en     = '0;
      branch_sel = 4'd0;
    end else begin
      branch_sel = cur_br_s;
      if (en && ((state_q == LOCKED) || sync_in)) begin
        buf_en = br_onehot(cur_br_s);
      end else begin
        buf_en = '0;
      end
    end
  end

  // Alignment FSM and counters.
  always_comb begin
    state_d    = state_q;
    nxt_br_d   = nxt_br_q;
    byte_cnt_d = byte_cnt_q;
    miss_cnt_d = miss_cnt_q;
    fill_cnt_d = fill_cnt_q;
    pkt_err_d  = 1'b0;
    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync_in) begin
            state_d    = LOCKED;
            nxt_br_d   = 4'd1;
            byte_cnt_d = BCW'(1);
            miss_cnt_d = 2'd0;
            fill_cnt_d = 12'd1;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (misplaced_s) begin
            pkt_err_d  = 1'b1;
            nxt_br_d   = 4'd1;
            byte_cnt_d = BCW'(1);
            miss_cnt_d = 2'd0;
            fill_cnt_d = 12'd1;
          end else if (missing_s && (miss_cnt_q == 2'd2)) begin
            state_d    = HUNT;
            nxt_br_d   = 4'd0;
            byte_cnt_d = '0;
            miss_cnt_d = 2'd0;
            fill_cnt_d = 12'd0;
          end else begin
            nxt_br_d   = (cur_br_s == LAST_BR) ? 4'd0 : cur_br_s + 4'd1;
            byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + BCW'(1);
            fill_cnt_d = (fill_cnt_q == FILL) ? FILL : fill_cnt_q + 12'd1;
            if (missing_s) begin
              miss_cnt_d = miss_cnt_q + 2'd1;
            end else if (byte_cnt_q == '0) begin
              miss_cnt_d = 2'd0;
            end else begin
              miss_cnt_d = miss_cnt_q;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end else begin
      pkt_err_d = 1'b0;
    end
    locked_d    = (state_d == LOCKED);
    fill_done_d = (fill_cnt_d == FILL);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= HUNT;
      nxt_br_q    <= 4'd0;
      byte_cnt_q  <= '0;
      miss_cnt_q  <= 2'd0;
      fill_cnt_q  <= 12'd0;
      locked_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nxt_br_q    <= nxt_br_d;
      byte_cnt_q  <= byte_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      locked_q    <= locked_d;
      pkt_err_q   <= pkt_err_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign locked    = locked_q;
  assign pkt_err   = pkt_err_q;
  assign fill_done = fill_done_q;

endmodule

// File: tb/tb_interleaver_commutator_ctrl.sv
// Directed bench for interleaver_commutator_ctrl: a packet-position model
// predicts every output each cycle, plus literal checks on key scenarios.
module tb_interleaver_commutator_ctrl;

  localparam int BR   = 12;
  localparam int DP   = 17;
  localparam int PKT  = 204;
  localparam int FILL = DP * BR * (BR - 1);

  logic          clk;
  logic          reset;
  logic          en;
  logic          sync_in;
  logic [BR-1:0] buf_en;
  logic [3:0]    branch_sel;
  logic          locked;
  logic          pkt_err;
  logic          fill_done;

  interleaver_commutator_ctrl #(.BRANCHES(BR), .DEPTH(DP), .PKT_LEN(PKT)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sync_in    (sync_in),
    .buf_en     (buf_en),
    .branch_sel (branch_sel),
    .locked     (locked),
    .pkt_err    (pkt_err),
    .fill_done  (fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: alignment flag, position within packet, consecutive misses, fill.
  bit m_locked = 1'b0;
  int m_pos    = 0;
  int m_miss   = 0;
  int m_fill   = 0;
  bit m_err    = 1'b0;

  int            tot = 0;
  logic [BR-1:0] s_buf_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_comb();
    int            br;
    logic [BR-1:0] eb;
    br = 0;
    if (m_locked) br = (en && sync_in && m_pos != 0) ? 0 : m_pos % BR;
    if (!reset) br = 0;
    eb = (reset && en && (m_locked || sync_in)) ? (12'h001 << br) : 12'h000;
    chk("buf_en", 32'(buf_en), 32'(eb));
    chk("branch_sel", 32'(branch_sel), 32'(br));
    if (reset && m_locked && en && sync_in && m_pos == 0)
      chk("sync_on_branch0", 32'(branch_sel), 32'd0);
    s_buf_en = buf_en;
  endtask

  task automatic model_update();
    m_err = 1'b0;
    if (!reset) begin
      m_locked = 1'b0; m_pos = 0; m_miss = 0; m_fill = 0;
    end else if (en) begin
      if (!m_locked) begin
        if (sync_in) begin
          m_locked = 1'b1; m_pos = 1; m_miss = 0; m_fill = 1;
        end
      end else if (sync_in && m_pos != 0) begin
        m_err = 1'b1; m_pos = 1; m_miss = 0; m_fill = 1;
      end else begin
        if (m_pos == 0) m_miss = sync_in ? 0 : m_miss + 1;
        if (m_miss == 3) begin
          m_locked = 1'b0; m_pos = 0; m_miss = 0; m_fill = 0;
        end else begin
          m_pos = (m_pos + 1) % PKT;
          if (m_fill < FILL) m_fill++;
        end
      end
    end
  endtask

  task automatic check_regs();
    chk("locked", 32'(locked), 32'(m_locked));
    chk("pkt_err", 32'(pkt_err), 32'(m_err));
    chk("fill_done", 32'(fill_done), 32'(m_fill == FILL));
  endtask

  task automatic apply(input logic e, input logic s, input logic r);
    @(negedge clk);
    en = e; sync_in = s; reset = r;
    #1;
    check_comb();
    @(posedge clk);
    model_update();
    #1;
    check_regs();
  endtask

  task automatic send(input logic e, input logic s);
    apply(e, s, 1'b1);
    if (e) tot++;
  endtask

  initial begin
    logic e;
    reset = 1'b0; en = 1'b0; sync_in = 1'b0;

    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    chk("rst_buf_en_with_en", 32'(s_buf_en), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);

    // Hunting: unsynced bytes are discarded.
    repeat (50) send(1'b1, 1'b0);
    chk("hunt_locked", 32'(locked), 32'h0);

    // Lock and commutate across two branch rotations.
    tot = 0;
    for (int k = 0; k < 24; k++) begin
      send(1'b1, k == 0);
      chk("commutate", 32'(s_buf_en), 32'(12'h001 << (k % BR)));
      if (k == 0) chk("lock_after_sync", 32'(locked), 32'h1);
      if (k == 11) chk("last_branch", 32'(s_buf_en), 32'h800);
    end

    // Regular packets with idle gaps until the buffers are full.
    while (tot < 2300) begin
      e = ($urandom_range(0, 3) != 0);
      send(e, e && (m_pos == 0));
      if (e && tot == 2243) chk("fill_pre", 32'(fill_done), 32'h0);
      if (e && tot == 2244) chk("fill_rise", 32'(fill_done), 32'h1);
    end

    // Misplaced sync at byte 100.
    while (m_pos != 100) send(1'b1, m_pos == 0);
    send(1'b1, 1'b1);
    chk("misplaced_err", 32'(pkt_err), 32'h1);
    chk("misplaced_br0", 32'(s_buf_en), 32'h001);
    send(1'b1, 1'b0);
    chk("realign_br1", 32'(s_buf_en), 32'h002);
    chk("err_one_cycle", 32'(pkt_err), 32'h0);

    // Three missing syncs drop lock.
    for (int b = 1; b <= 3; b++) begin
      while (m_pos != 0) send(1'b1, 1'b0);
      chk("still_locked", 32'(locked), 32'h1);
      send(1'b1, 1'b0);
    end
    chk("unlock", 32'(locked), 32'h0);
    chk("unlock_fill", 32'(fill_done), 32'h0);
    repeat (20) begin
      send(1'b1, 1'b0);
      chk("unlocked_quiet", 32'(s_buf_en), 32'h0);
    end

    // Reset at byte 77, then relock on the next sync.
    send(1'b1, 1'b1);
    repeat (76) send(1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    chk("midrst_buf_en", 32'(s_buf_en), 32'h0);
    chk("midrst_locked", 32'(locked), 32'h0);
    chk("midrst_err", 32'(pkt_err), 32'h0);
    chk("midrst_fill", 32'(fill_done), 32'h0);
    repeat (10) begin
      send(1'b1, 1'b0);
      chk("post_rst_hunt", 32'(locked), 32'h0);
    end
    send(1'b1, 1'b1);
    chk("relock_br0", 32'(s_buf_en), 32'h001);
    chk("relock", 32'(locked), 32'h1);
    repeat (5) send(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interleaver_commutator_ctrl.md
INTERLEAVER_COMMUTATOR_CTRL -- requirements
Module: interleaver_commutator_ctrl

Interface
REQ-001 The block SHALL have parameter BRANCHES, default 12, meaning the number of interleaver branches.
REQ-002 The block SHALL have parameter DEPTH, default 17, meaning the delay step per branch in bytes.
REQ-003 The block SHALL have parameter PKT_LEN, default 204, meaning the bytes per packet, including the sync byte.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: byte strobe, meaning one data byte is present this cycle.
REQ-007 The block SHALL have port sync_in, input, 1 bit: packet-start marker, meaningful only when en=1.
REQ-008 The block SHALL have port buf_en, output, BRANCHES bits: one-hot enable for the branch buffer that takes the current byte.
REQ-009 The block SHALL have port branch_sel, output, 4 bits: index of the branch for the current byte, used by the output mux.
REQ-010 The block SHALL have port locked, output, 1 bit: packet alignment established.
REQ-011 The block SHALL have port pkt_err, output, 1 bit: one-cycle pulse on a misplaced sync.
REQ-012 The block SHALL have port fill_done, output, 1 bit: high once all branch buffers hold valid data.

Function
REQ-013 The block SHALL implement two states: HUNT and LOCKED.
REQ-014 The block SHALL hold these registers: nxt_br (0..BRANCHES-1), byte_cnt (0..PKT_LEN-1), miss_cnt (0..3), fill_cnt (12 bits, saturating at FILL = DEPTH*BRANCHES*(BRANCHES-1) = 2244).
REQ-015 The current branch cur_br SHALL be 0 when en&sync_in is high in HUNT, or in LOCKED with byte_cnt!=0; otherwise cur_br SHALL equal nxt_br.
REQ-016 branch_sel SHALL be driven combinationally to cur_br.
REQ-017 buf_en SHALL be driven combinationally to the one-hot decode of cur_br, gated by en.
REQ-018 In HUNT, buf_en SHALL be asserted only for a sync byte.
REQ-019 While en=0, buf_en SHALL be all zeros, no register SHALL change, and pkt_err SHALL be 0 the next cycle.
REQ-020 HUNT, en&sync_in: the next state SHALL be LOCKED, nxt_br=1, byte_cnt=1, miss_cnt=0, fill_cnt=1.
REQ-021 HUNT, en without sync_in: the byte SHALL be discarded, with no state change.
REQ-022 LOCKED, each en: nxt_br SHALL be set to cur_br+1, wrapping BRANCHES-1 to 0.
REQ-023 LOCKED, each en: byte_cnt SHALL be incremented, wrapping PKT_LEN-1 to 0.
REQ-024 LOCKED, each en: fill_cnt SHALL be incremented, saturating at FILL.
REQ-025 LOCKED, en&sync_in&byte_cnt==0 (expected sync): miss_cnt SHALL be cleared.
REQ-026 LOCKED, en&sync_in&byte_cnt!=0 (misplaced sync): pkt_err SHALL be 1 the next cycle.
REQ-027 On a misplaced sync, the byte SHALL be realigned to branch 0, with nxt_br=1, byte_cnt=1, miss_cnt=0, fill_cnt=1.
REQ-028 LOCKED, en&!sync_in&byte_cnt==0 (missing sync): the byte SHALL be dispatched normally and miss_cnt incremented.
REQ-029 When miss_cnt would reach 3, the next state SHALL be HUNT, with nxt_br=0, byte_cnt=0, miss_cnt=0, fill_cnt=0.
REQ-030 locked SHALL be a registered output, equal to 1 exactly when the state is LOCKED.
REQ-031 fill_done SHALL be a registered output, equal to 1 exactly when fill_cnt==FILL.
REQ-032 Because PKT_LEN mod BRANCHES = 0, an expected sync SHALL always fall on nxt_br==0; the bench SHALL check this.

Reset
REQ-033 reset low at a rising edge SHALL force: state HUNT, nxt_br=0, byte_cnt=0, miss_cnt=0, fill_cnt=0, locked=0, pkt_err=0, fill_done=0.
REQ-034 While reset is low, buf_en SHALL be 0 and branch_sel SHALL be 0, regardless of en.
REQ-035 Reset asserted mid-packet SHALL discard alignment; the block SHALL then require a new sync to relock.

Verification
REQ-036 Scenario: release reset, send 50 bytes with sync_in=0 -> buf_en stays 0x000 and locked stays 0.
REQ-037 Scenario: send a sync byte, then 23 bytes -> buf_en runs 0x001,0x002,...,0x800,0x001,...,0x800, and locked=1 from the cycle after the sync byte.
REQ-038 Scenario: send syncs every 204 bytes, with random en gaps -> fill_done rises the cycle after the 2244th enabled byte, and pkt_err never pulses.
REQ-039 Scenario: while locked, send a sync at byte_cnt=100 -> pkt_err pulses for one cycle, that byte has buf_en=0x001, and the next byte has 0x002.
REQ-040 Scenario: lock, then omit sync at three consecutive packet boundaries -> locked falls after the third boundary byte, fill_done=0, and buf_en=0 until the next sync.
REQ-041 Scenario: assert reset for one cycle at byte 77 of a packet -> all outputs are 0 after that edge, and relock occurs on the next sync.
